// File: rtl/npu_cube_pkg.sv
// Shared widths and sign-extension prefix encodings for the cube partial-product extension stage.
package npu_cube_pkg;

  localparam int PP_EXT0_PAD = 3;
  localparam int PP_EXTK_PAD = 2;

  // Constant-compensation prefixes: line0 gets {~s,s,s}, line k gets {1,~s}.
  localparam logic [PP_EXT0_PAD-1:0] PFX0_NEG = 3'b011;
  localparam logic [PP_EXT0_PAD-1:0] PFX0_POS = 3'b100;
  localparam logic [PP_EXT0_PAD-1:0] PFX0_UNS = 3'b000;
  localparam logic [PP_EXTK_PAD-1:0] PFXK_NEG = 2'b10;
  localparam logic [PP_EXTK_PAD-1:0] PFXK_POS = 2'b11;
  localparam logic [PP_EXTK_PAD-1:0] PFXK_UNS = 2'b00;

  function automatic int line0_w(input int dw);
    return dw + PP_EXT0_PAD;
  endfunction

  function automatic int linek_w(input int dw);
    return dw + PP_EXTK_PAD;
  endfunction

endpackage

// File: rtl/npu_cube_pp_extend_ch.sv
// Combinational sign/zero extension and masking of one MAC channel's Booth partial-product lines.
module npu_cube_pp_extend_ch
  import npu_cube_pkg::*;
#(
  parameter int PP_NUM  = 4,
  parameter int DWPPLEN = 10
) (
  input  logic [PP_NUM*DWPPLEN-1:0]                       pp_i,
  input  logic                                            is_signed_i,
  input  logic                                            mask_i,
  output logic [DWPPLEN+PP_EXT0_PAD-1:0]                  line0_o,
  output logic [(PP_NUM-1)*(DWPPLEN+PP_EXTK_PAD)-1:0]     lines_o
);

  localparam int LKW = DWPPLEN + PP_EXTK_PAD;

  logic [DWPPLEN-1:0]     pp0;
  logic [DWPPLEN-1:0]     ppk;
  logic [PP_EXT0_PAD-1:0] pfx0;
  logic [PP_EXTK_PAD-1:0] pfxk;

  always_comb begin
    line0_o = '0;
    lines_o = '0;
    pp0     = pp_i[DWPPLEN-1:0];
    ppk     = '0;
    pfx0    = PFX0_UNS;
    pfxk    = PFXK_UNS;
    if (mask_i) begin
      if (is_signed_i) begin
        pfx0 = pp0[DWPPLEN-1] ? PFX0_NEG : PFX0_POS;
      end
      line0_o = {pfx0, pp0};
      for (int k = 1; k < PP_NUM; k++) begin
        ppk  = pp_i[k*DWPPLEN +: DWPPLEN];
        pfxk = PFXK_UNS;
        if (is_signed_i) begin
          pfxk = ppk[DWPPLEN-1] ? PFXK_NEG : PFXK_POS;
        end
        lines_o[(k-1)*LKW +: LKW] = {pfxk, ppk};
      end
    end
  end

endmodule

// File: rtl/npu_cube_pp_extend_pipe.sv
// Pipelined partial-product extension stage with valid/ready skid buffer.
// Define NPU_PP_EXT_STAT_EN to enable the saturating output beat counter.
module npu_cube_pp_extend_pipe
  import npu_cube_pkg::*;
#(
  parameter int NPU_CUBE_MAC_NUM = 8,
  parameter int PP_NUM           = 4,
  parameter int DWPPLEN          = 10,
  parameter int CNT_W            = 32
) (
  input  logic                                                      clk,
  input  logic                                                      rst_n,
  input  logic                                                      in_valid,
  output logic                                                      in_ready,
  input  logic [DWPPLEN*PP_NUM*NPU_CUBE_MAC_NUM-1:0]                in_pp,
  input  logic                                                      in_is_signed,
  input  logic [NPU_CUBE_MAC_NUM-1:0]                               in_ch_mask,
  output logic                                                      out_valid,
  input  logic                                                      out_ready,
  output logic [(DWPPLEN+PP_EXT0_PAD)*NPU_CUBE_MAC_NUM-1:0]         out_line0,
  output logic [(DWPPLEN+PP_EXTK_PAD)*(PP_NUM-1)*NPU_CUBE_MAC_NUM-1:0] out_lines,
  output logic [CNT_W-1:0]                                          beat_cnt
);

  localparam int L0W = line0_w(DWPPLEN);
  localparam int LKW = linek_w(DWPPLEN);
  localparam int CHW = PP_NUM * DWPPLEN;
  localparam int CKW = (PP_NUM - 1) * LKW;
  localparam int O0W = L0W * NPU_CUBE_MAC_NUM;
  localparam int OKW = CKW * NPU_CUBE_MAC_NUM;

  logic [O0W-1:0] ext_line0;
  logic [OKW-1:0] ext_lines;

  for (genvar i = 0; i < NPU_CUBE_MAC_NUM; i++) begin : g_ch
    npu_cube_pp_extend_ch #(
      .PP_NUM  (PP_NUM),
      .DWPPLEN (DWPPLEN)
    ) u_ch (
      .pp_i        (in_pp[i*CHW +: CHW]),
      .is_signed_i (in_is_signed),
      .mask_i      (in_ch_mask[i]),
      .line0_o     (ext_line0[i*L0W +: L0W]),
      .lines_o     (ext_lines[i*CKW +: CKW])
    );
  end

  logic           m_valid_q, m_valid_d;
  logic           s_full_q,  s_full_d;
  logic [O0W-1:0] m_line0_q, m_line0_d, s_line0_q, s_line0_d;
  logic [OKW-1:0] m_lines_q, m_lines_d, s_lines_q, s_lines_d;
  logic           in_xfer;
  logic           m_free;

  assign in_xfer = in_valid & ~s_full_q;
  assign m_free  = ~m_valid_q | out_ready;

  // M refills from S first so arrival order is preserved; S only catches a beat M cannot take.
  always_comb begin
    m_valid_d = m_valid_q;
    s_full_d  = s_full_q;
    m_line0_d = m_line0_q;
    m_lines_d = m_lines_q;
    s_line0_d = s_line0_q;
    s_lines_d = s_lines_q;
    if (m_free) begin
      if (s_full_q) begin
        m_valid_d = 1'b1;
        m_line0_d = s_line0_q;
        m_lines_d = s_lines_q;
        s_full_d  = 1'b0;
      end else if (in_xfer) begin
        m_valid_d = 1'b1;
        m_line0_d = ext_line0;
        m_lines_d = ext_lines;
      end else begin
        m_valid_d = 1'b0;
      end
    end else if (in_xfer) begin
      s_full_d  = 1'b1;
      s_line0_d = ext_line0;
      s_lines_d = ext_lines;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid_q <= 1'b0;
      s_full_q  <= 1'b0;
      m_line0_q <= '0;
      m_lines_q <= '0;
      s_line0_q <= '0;
      s_lines_q <= '0;
    end else begin
      m_valid_q <= m_valid_d;
      s_full_q  <= s_full_d;
      m_line0_q <= m_line0_d;
      m_lines_q <= m_lines_d;
      s_line0_q <= s_line0_d;
      s_lines_q <= s_lines_d;
    end
  end

  assign in_ready  = ~s_full_q;
  assign out_valid = m_valid_q;
  assign out_line0 = m_line0_q;
  assign out_lines = m_lines_q;

`ifdef NPU_PP_EXT_STAT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (m_valid_q && out_ready && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign beat_cnt = cnt_q;
`else
  assign beat_cnt = '0;
`endif

endmodule

// File: tb/tb_npu_cube_pp_extend_pipe.sv
// Directed and streaming checks for npu_cube_pp_extend_pipe at default parameters.
module tb_npu_cube_pp_extend_pipe;

  localparam int N   = 8;
  localparam int P   = 4;
  localparam int DW  = 10;
  localparam int L0W = 13;
  localparam int LKW = 12;
  localparam int PPW = DW * P * N;
  localparam int O0W = L0W * N;
  localparam int OKW = LKW * (P - 1) * N;
  localparam int NBEATS = 1000;
`ifdef NPU_PP_EXT_STAT_EN
  localparam logic [31:0] EXP_CNT = 32'd1000;
`else
  localparam logic [31:0] EXP_CNT = 32'd0;
`endif

  logic           clk;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [PPW-1:0] in_pp;
  logic           in_is_signed;
  logic [N-1:0]   in_ch_mask;
  logic           out_valid;
  logic           out_ready;
  logic [O0W-1:0] out_line0;
  logic [OKW-1:0] out_lines;
  logic [31:0]    beat_cnt;

  int errors = 0;
  int checks = 0;

  npu_cube_pp_extend_pipe dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_pp        (in_pp),
    .in_is_signed (in_is_signed),
    .in_ch_mask   (in_ch_mask),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_line0    (out_line0),
    .out_lines    (out_lines),
    .beat_cnt     (beat_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // Reference: signed line = sign-extended value plus the compensation constant.
  function automatic logic [O0W-1:0] m_line0(input logic [PPW-1:0] pp, input logic sg,
                                             input logic [N-1:0] mk);
    logic [O0W-1:0] r;
    logic [L0W-1:0] v;
    logic [DW-1:0]  p;
    r = '0;
    for (int i = 0; i < N; i++) begin
      p = pp[(i*P)*DW +: DW];
      if (sg) v = {{(L0W-DW){p[DW-1]}}, p} + 13'h1000;
      else    v = {{(L0W-DW){1'b0}}, p};
      if (!mk[i]) v = '0;
      r[i*L0W +: L0W] = v;
    end
    return r;
  endfunction

  function automatic logic [OKW-1:0] m_lines(input logic [PPW-1:0] pp, input logic sg,
                                             input logic [N-1:0] mk);
    logic [OKW-1:0] r;
    logic [LKW-1:0] v;
    logic [DW-1:0]  p;
    r = '0;
    for (int i = 0; i < N; i++) begin
      for (int k = 1; k < P; k++) begin
        p = pp[(i*P+k)*DW +: DW];
        if (sg) v = {{(LKW-DW){p[DW-1]}}, p} + 12'hC00;
        else    v = {{(LKW-DW){1'b0}}, p};
        if (!mk[i]) v = '0;
        r[(i*(P-1)+k-1)*LKW +: LKW] = v;
      end
    end
    return r;
  endfunction

  function automatic logic [PPW-1:0] rand_pp();
    logic [PPW-1:0] r;
    for (int w = 0; w < PPW/32; w++) r[w*32 +: 32] = $urandom();
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_pp = '0; in_is_signed = 1'b0;
    in_ch_mask = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %0b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %0b want 1", in_ready); end
    checks++; if (out_line0 !== '0 || out_lines !== '0) begin errors++; $display("FAIL rst_data got %h/%h want 0", out_line0, out_lines); end
    checks++; if (beat_cnt !== 32'd0) begin errors++; $display("FAIL rst_beat_cnt got %0d want 0", beat_cnt); end
    rst_n = 1'b1;
    step();
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL post_rst got rdy=%0b vld=%0b want 1/0", in_ready, out_valid); end
  endtask

  task automatic test_signed();
    in_pp = '0; in_pp[9:0] = 10'h3FF; in_pp[19:10] = 10'h200;
    in_is_signed = 1'b1; in_ch_mask = 8'hFF; out_ready = 1'b1; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL sgn_valid got %0b want 1", out_valid); end
    checks++; if (out_line0[12:0] !== 13'h0FFF) begin errors++; $display("FAIL sgn_line0 got %h want 0fff", out_line0[12:0]); end
    checks++; if (out_lines[11:0] !== 12'hA00) begin errors++; $display("FAIL sgn_line1 got %h want a00", out_lines[11:0]); end
    checks++; if (out_line0 !== m_line0(in_pp, 1'b1, 8'hFF) || out_lines !== m_lines(in_pp, 1'b1, 8'hFF)) begin
      errors++; $display("FAIL sgn_full got %h/%h", out_line0, out_lines); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL sgn_drain got %0b want 0", out_valid); end
  endtask

  task automatic test_unsigned();
    in_pp = '0; in_pp[9:0] = 10'h3FF; in_pp[19:10] = 10'h200;
    in_is_signed = 1'b0; in_valid = 1'b1;
    step();
    checks++; if (out_line0[12:0] !== 13'h03FF || out_lines[11:0] !== 12'h200) begin
      errors++; $display("FAIL uns_lines got %h/%h want 03ff/200", out_line0[12:0], out_lines[11:0]); end
    in_pp = '0;
    for (int k = 0; k < P; k++) in_pp[k*DW +: DW] = 10'h005;
    in_is_signed = 1'b1;
    step();
    in_valid = 1'b0;
    checks++; if (out_line0[12:0] !== 13'h1005) begin errors++; $display("FAIL pos_line0 got %h want 1005", out_line0[12:0]); end
    checks++; if (out_lines[11:0] !== 12'hC05 || out_lines[35:24] !== 12'hC05) begin
      errors++; $display("FAIL pos_linek got %h/%h want c05", out_lines[11:0], out_lines[35:24]); end
    step();
  endtask

  task automatic test_mask();
    for (int j = 0; j < P*N; j++) in_pp[j*DW +: DW] = 10'h3FF;
    in_is_signed = 1'b1; in_ch_mask = 8'b1111_1110; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    checks++; if (out_line0[12:0] !== 13'h0 || out_lines[35:0] !== 36'h0) begin
      errors++; $display("FAIL mask_ch0 got %h/%h want 0", out_line0[12:0], out_lines[35:0]); end
    checks++; if (out_line0[25:13] !== 13'h0FFF || out_line0[103:91] !== 13'h0FFF) begin
      errors++; $display("FAIL mask_ch17 got %h/%h want 0fff", out_line0[25:13], out_line0[103:91]); end
    checks++; if (out_lines[3*36 +: 12] !== 12'hBFF) begin errors++; $display("FAIL mask_ch3_l1 got %h want bff", out_lines[3*36 +: 12]); end
    in_ch_mask = 8'hFF;
    step();
  endtask

  task automatic test_back_to_back();
    logic [PPW-1:0] pa, pb, pc;
    pa = rand_pp(); pb = rand_pp(); pc = rand_pp();
    in_is_signed = 1'b1; in_ch_mask = 8'hFF; out_ready = 1'b0;
    in_pp = pa; in_valid = 1'b1;
    step();
    checks++; if (out_valid !== 1'b1 || in_ready !== 1'b1 || out_line0 !== m_line0(pa, 1'b1, 8'hFF)) begin
      errors++; $display("FAIL bp_a_in_m got vld=%0b rdy=%0b l0=%h", out_valid, in_ready, out_line0); end
    in_pp = pb;
    step();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_skid_full got rdy=%0b want 0", in_ready); end
    checks++; if (out_lines !== m_lines(pa, 1'b1, 8'hFF)) begin errors++; $display("FAIL bp_a_stable got %h", out_lines); end
    in_pp = pc;
    step();
    checks++; if (in_ready !== 1'b0 || out_line0 !== m_line0(pa, 1'b1, 8'hFF)) begin
      errors++; $display("FAIL bp_c_held got rdy=%0b l0=%h", in_ready, out_line0); end
    out_ready = 1'b1;
    step();
    checks++; if (out_valid !== 1'b1 || out_line0 !== m_line0(pb, 1'b1, 8'hFF) || out_lines !== m_lines(pb, 1'b1, 8'hFF)) begin
      errors++; $display("FAIL bp_b_out got vld=%0b l0=%h", out_valid, out_line0); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_rdy_rise got %0b want 1", in_ready); end
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_line0 !== m_line0(pc, 1'b1, 8'hFF) || out_lines !== m_lines(pc, 1'b1, 8'hFF)) begin
      errors++; $display("FAIL bp_c_out got vld=%0b l0=%h", out_valid, out_line0); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_empty got %0b want 0", out_valid); end
  endtask

  task automatic test_mid_reset();
    logic [PPW-1:0] pd;
    out_ready = 1'b0; in_valid = 1'b1; in_pp = rand_pp();
    step();
    in_pp = rand_pp();
    step();
    in_valid = 1'b0;
    checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      errors++; $display("FAIL mrst_pre got rdy=%0b vld=%0b want 0/1", in_ready, out_valid); end
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || beat_cnt !== 32'd0 || out_line0 !== '0) begin
      errors++; $display("FAIL mrst_now got vld=%0b rdy=%0b cnt=%0d", out_valid, in_ready, beat_cnt); end
    @(negedge clk);
    rst_n = 1'b1;
    pd = rand_pp(); in_pp = pd; in_is_signed = 1'b0; in_ch_mask = 8'h5A;
    in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_line0 !== m_line0(pd, 1'b0, 8'h5A) || out_lines !== m_lines(pd, 1'b0, 8'h5A)) begin
      errors++; $display("FAIL mrst_first got vld=%0b l0=%h", out_valid, out_line0); end
    step();
  endtask

  task automatic test_stream();
    logic [O0W-1:0] q0[$];
    logic [OKW-1:0] qk[$];
    logic [PPW-1:0] cp;
    logic           cs;
    logic [N-1:0]   cm;
    int sent, recv, cyc;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    sent = 0; recv = 0; cyc = 0;
    cp = rand_pp(); cs = 1'($urandom_range(0, 1));
    cm = ($urandom_range(0, 1) != 0) ? 8'hFF : 8'($urandom());
    while (recv < NBEATS && cyc < 20000) begin
      out_ready = ($urandom_range(0, 3) != 0);
      in_valid  = (sent < NBEATS) && ($urandom_range(0, 4) != 0);
      in_pp = cp; in_is_signed = cs; in_ch_mask = cm;
      #1;
      if (out_valid && out_ready) begin
        checks++;
        if (q0.size() == 0) begin
          errors++; $display("FAIL stream_extra beat %0d got %h want none", recv, out_line0);
        end else begin
          if (out_line0 !== q0[0] || out_lines !== qk[0]) begin
            errors++; $display("FAIL stream_beat %0d got %h want %h", recv, out_line0, q0[0]);
          end
          void'(q0.pop_front()); void'(qk.pop_front());
        end
        recv++;
      end
      if (in_valid && in_ready) begin
        q0.push_back(m_line0(cp, cs, cm));
        qk.push_back(m_lines(cp, cs, cm));
        sent++;
        cp = rand_pp(); cs = 1'($urandom_range(0, 1));
        cm = ($urandom_range(0, 1) != 0) ? 8'hFF : 8'($urandom());
      end
      step();
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    checks++; if (recv !== NBEATS || q0.size() != 0) begin
      errors++; $display("FAIL stream_count got %0d left %0d want %0d", recv, q0.size(), NBEATS); end
    checks++; if (beat_cnt !== EXP_CNT) begin errors++; $display("FAIL beat_cnt got %0d want %0d", beat_cnt, EXP_CNT); end
  endtask

  initial begin
    test_reset();
    test_signed();
    test_unsigned();
    test_mask();
    test_back_to_back();
    test_mid_reset();
    test_stream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/npu_cube_pp_extend_pipe.md
Name: npu_cube_pp_extend_pipe

Overview:
- Parametrised, pipelined successor to the cube add-tree sign-extension stage.
- Per MAC channel, takes PP_NUM Booth partial-product lines, applies the constant-compensation sign-extension prefix (signed mode) or zero-extension (unsigned mode), and applies a per-channel mask.
- Registers the result behind a valid/ready handshake with a skid buffer.
- Sits between the Booth partial-product generator and the Wallace compressor tree.

Parameters:
- NPU_CUBE_MAC_NUM, 8, number of MAC channels.
- PP_NUM, 4, partial-product lines per channel (>=2); line k is weighted by 4^k.
- DWPPLEN, 10, width of one raw partial-product line; its MSB is the line sign s_k.
- CNT_W, 32, width of the beat statistics counter (optional feature only).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input can accept; registered.
- in_pp  in  DWPPLEN*PP_NUM*NPU_CUBE_MAC_NUM  channel i line k at bit offset (i*PP_NUM+k)*DWPPLEN.
- in_is_signed  in  1  per-beat mode, sampled with data.
- in_ch_mask  in  NPU_CUBE_MAC_NUM  1 = channel active, 0 = force all of that channel's outputs to zero.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accept.
- out_line0  out  (DWPPLEN+3)*NPU_CUBE_MAC_NUM  channel i at offset i*(DWPPLEN+3).
- out_lines  out  (DWPPLEN+2)*(PP_NUM-1)*NPU_CUBE_MAC_NUM  channel i line k (k>=1) at offset (i*(PP_NUM-1)+k-1)*(DWPPLEN+2).
- beat_cnt  out  CNT_W  accepted output beats (only with NPU_PP_EXT_STAT_EN).

Behaviour:
- Extension, signed mode:
  - line0 = {~s0, s0, s0, pp0}.
  - line k>=1 = {1'b1, ~sk, ppk}.
- Extension, unsigned mode: line0 = {3'b000, pp0}; line k = {2'b00, ppk}.
- Masked channel: every output bit of that channel is 0, prefix bits included.
- Extension is combinational on the input side. Result, mode and mask are captured together in one beat.
- Storage: main output register (M) plus one-entry skid register (S).
- Handshake:
  - Transfer in = in_valid & in_ready. Transfer out = out_valid & out_ready.
  - in_ready = ~S_full.
  - When M is empty or being drained, M loads from S if S_full, else from the input transfer.
  - If M is full and not draining while an input transfer occurs, the beat goes into S.
- Latency and throughput: 1 cycle from input transfer to out_valid when idle. Sustained throughput is 1 beat per cycle.
- Ordering: beats leave in arrival order. No beat is dropped or duplicated.
- Stability: while out_valid & ~out_ready, the output data is held stable.
- Simultaneous events:
  - S full, out_ready=1: M takes S, S empties, in_ready rises next cycle.
  - M full, out_ready=1, in_valid=1, S empty: M takes the input directly.
- Reset: async assert clears M_valid, S_full, beat_cnt and all data registers to 0. Consequences:
  - out_valid=0, outputs 0, in_ready=1 while in reset and on the first cycle after reset.
  - A mid-operation reset discards buffered beats.
- Deassertion of rst_n is synchronised externally.

Optional Feature:
- Macro: NPU_PP_EXT_STAT_EN.
- Defined:
  - beat_cnt increments on each output transfer.
  - It saturates at all-ones and does not wrap.
  - It is cleared only by reset.
- Undefined: beat_cnt is tied to 0 and no counter flops exist.

Decomposition:
- Package npu_cube_pkg holds:
  - Width helper constants: line0 extended width DWPPLEN+3, line-k width DWPPLEN+2.
  - The prefix encodings for line0 and line k as named constants.
- Natural sub-module: npu_cube_pp_extend_ch, the purely combinational extension/mask of one channel. It is instantiated NPU_CUBE_MAC_NUM times by a generate loop.
- The skid/handshake logic stays in the top.

Test Plan (default parameters):
- Signed beat: channel 0 pp0=10'h3FF, pp1=10'h200, mask=all 1, out_ready=1 -> one cycle later out_valid=1, ch0 line0=13'h0FFF, ch0 line1=12'hA00.
- Same pp with in_is_signed=0 -> line0=13'h03FF, line1=12'h200; positive pp 10'h005 signed -> line0=13'h1005, line k=12'hC05.
- Mask 8'b1111_1110, all pp=10'h3FF signed -> channel 0 outputs all zero, channels 1-7 line0=13'h0FFF.
- Backpressure:
  - Stimulus: out_ready=0, push beats A, B, C.
  - Required: A stays in M, B goes to S, in_ready=0 after B, C is held upstream.
  - Release out_ready -> A, B, C emerge in order, one per cycle, data unchanged.
- Streaming with random out_ready over 1000 beats against a scoreboard -> no loss or reorder. With NPU_PP_EXT_STAT_EN, beat_cnt=1000.
- Assert rst_n low with M and S full -> out_valid=0, in_ready=1, beat_cnt=0 immediately. The first beat after release appears with 1-cycle latency.
